// File: rtl/otp_pkg.sv
// Shared definitions for the one-time-pad arbiter.
//   OTP_WIDTH / OTP_DEPTH : default key byte width and pad storage depth
//   otp_state_e           : controller states (IDLE, ISSUE, WIPE)
package otp_pkg;
  localparam int OTP_WIDTH = 8;
  localparam int OTP_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WIPE  = 2'd2
  } otp_state_e;
endpackage

// File: rtl/otp_rr_arbiter.sv
// Two-way round-robin selector, purely combinational.
//   req    : request bits (bit 0 encryptor, bit 1 decryptor)
//   prio   : 0 -> requester 0 wins a tie, 1 -> requester 1 wins a tie
//   winner : one-hot winner, 0 when no request
module otp_rr_arbiter (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] winner
);
  always_comb begin
    winner = 2'b00;
    case (req)
      2'b01:   winner = 2'b01;
      2'b10:   winner = 2'b10;
      2'b11:   winner = prio ? 2'b10 : 2'b01;
      default: winner = 2'b00;
    endcase
  end
endmodule

// File: rtl/otp_pad_arbiter.sv
// One-time-pad key store with two-requester round-robin issue.
//   clk, reset            : clock, async active-high reset
//   load_valid/data/ready : pad byte load handshake
//   zeroize               : pulse, wipes all stored pad bytes
//   req                   : level requests (bit 0 encryptor, bit 1 decryptor)
//   grant, key_valid,
//   key_data              : one-cycle key issue to the granted requester
//   pad_count/empty/full  : occupancy of unused pad bytes
module otp_pad_arbiter
  import otp_pkg::*;
#(
  parameter int WIDTH = OTP_WIDTH,
  parameter int DEPTH = OTP_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_valid,
  input  logic [WIDTH-1:0]         load_data,
  output logic                     load_ready,
  input  logic                     zeroize,
  input  logic [1:0]               req,
  output logic [1:0]               grant,
  output logic                     key_valid,
  output logic [WIDTH-1:0]         key_data,
  output logic [$clog2(DEPTH):0]   pad_count,
  output logic                     pad_empty,
  output logic                     pad_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  otp_state_e      state, nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, wipe_cnt;
  logic [1:0]      grant_q, winner;
  logic            prio;
  logic            wr_en, rd_en;

  otp_rr_arbiter u_rr (
    .req    (req),
    .prio   (prio),
    .winner (winner)
  );

  assign pad_empty  = (pad_count == '0);
  assign pad_full   = (pad_count == CW'(DEPTH));
  // Gated by reset so the loader sees no ready while reset is held.
  assign load_ready = !reset && (state != WIPE) && !pad_full;
  assign wr_en      = load_valid && load_ready;
  assign rd_en      = (state == ISSUE);

  always_comb begin
    nxt       = state;
    key_valid = 1'b0;
    grant     = 2'b00;
    key_data  = '0;
    case (state)
      IDLE: begin
        if (zeroize)                       nxt = WIPE;
        else if (!pad_empty && (|req))     nxt = ISSUE;
      end
      ISSUE: begin
        key_valid = 1'b1;
        grant     = grant_q;
        key_data  = mem[rd_ptr];
        nxt       = zeroize ? WIPE : IDLE;
      end
      WIPE: begin
        if (wipe_cnt == AW'(DEPTH-1)) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      wipe_cnt  <= '0;
      pad_count <= '0;
      grant_q   <= 2'b00;
      prio      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= nxt;
      // Priority flips to the requester not just served; untouched by WIPE.
      if (state == IDLE && nxt == ISSUE) begin
        grant_q <= winner;
        prio    <= winner[0];
      end
      if (state == WIPE) begin
        mem[wipe_cnt] <= '0;
        wipe_cnt      <= wipe_cnt + 1'b1;
        if (nxt == IDLE) begin
          wr_ptr    <= '0;
          rd_ptr    <= '0;
          pad_count <= '0;
          wipe_cnt  <= '0;
        end
      end else begin
        // A write and an issue never hit the same entry: that would need
        // the FIFO full, which blocks the load.
        if (wr_en) begin
          mem[wr_ptr] <= load_data;
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (rd_en) begin
          mem[rd_ptr] <= '0;
          rd_ptr      <= rd_ptr + 1'b1;
        end
        pad_count <= pad_count + CW'(wr_en) - CW'(rd_en);
      end
    end
  end
endmodule

// File: tb/tb_otp_pad_arbiter.sv
module tb_otp_pad_arbiter;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             load_valid = 1'b0;
  logic [WIDTH-1:0] load_data = '0;
  logic             load_ready;
  logic             zeroize = 1'b0;
  logic [1:0]       req = 2'b00;
  logic [1:0]       grant;
  logic             key_valid;
  logic [WIDTH-1:0] key_data;
  logic [3:0]       pad_count;
  logic             pad_empty, pad_full;

  always #5 clk = ~clk;

  otp_pad_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .zeroize(zeroize), .req(req), .grant(grant),
    .key_valid(key_valid), .key_data(key_data), .pad_count(pad_count),
    .pad_empty(pad_empty), .pad_full(pad_full)
  );

  typedef struct {
    logic       lv;
    logic [7:0] ld;
    logic       zr;
    logic [1:0] rq;
    logic       use_exp;
    logic       e_kv;
    logic [1:0] e_grant;
    logic [7:0] e_data;
    int         e_count;
    logic       e_lr;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: queue of unused pad bytes plus the current activity.
  logic [7:0] q[$];
  bit         issuing;
  int         wipe_left;
  logic [1:0] cur_g, last_g;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    issuing   = 0;
    wipe_left = 0;
    cur_g     = 2'b00;
    last_g    = 2'b10;  // requester 0 goes first after reset
  endtask

  task automatic step(input vec_t v);
    logic       m_kv, m_lr, acc;
    logic [1:0] m_g;
    logic [7:0] m_d;
    int         m_cnt;
    load_valid = v.lv; load_data = v.ld; zeroize = v.zr; req = v.rq;
    m_kv  = issuing;
    m_g   = issuing ? cur_g : 2'b00;
    m_d   = issuing ? q[0] : 8'h00;
    m_cnt = q.size();
    m_lr  = (wipe_left == 0) && (q.size() < DEPTH);
    #3;
    chk("key_valid", int'(key_valid), int'(m_kv));
    chk("grant", int'(grant), int'(m_g));
    chk("key_data", int'(key_data), int'(m_d));
    chk("pad_count", int'(pad_count), m_cnt);
    chk("load_ready", int'(load_ready), int'(m_lr));
    chk("pad_empty", int'(pad_empty), int'(m_cnt == 0));
    chk("pad_full", int'(pad_full), int'(m_cnt == DEPTH));
    if (v.use_exp) begin
      chk("tab_key_valid", int'(key_valid), int'(v.e_kv));
      chk("tab_grant", int'(grant), int'(v.e_grant));
      chk("tab_key_data", int'(key_data), int'(v.e_data));
      chk("tab_pad_count", int'(pad_count), v.e_count);
      chk("tab_load_ready", int'(load_ready), int'(v.e_lr));
    end
    @(posedge clk);
    acc = v.lv && m_lr;
    if (wipe_left > 0) begin
      wipe_left--;
      if (wipe_left == 0) q.delete();
    end else if (issuing) begin
      void'(q.pop_front());
      if (acc) q.push_back(v.ld);
      issuing = 0;
      if (v.zr) wipe_left = DEPTH;
    end else begin
      if (v.zr) wipe_left = DEPTH;
      else if (q.size() > 0 && v.rq != 0) begin
        issuing = 1;
        if (v.rq == 2'b11) cur_g = (last_g == 2'b01) ? 2'b10 : 2'b01;
        else               cur_g = v.rq;
        last_g = cur_g;
      end
      if (acc) q.push_back(v.ld);
    end
    #1;
  endtask

  function automatic vec_t mk(input logic lv, input logic [7:0] ld,
                              input logic zr, input logic [1:0] rq);
    vec_t v;
    v = '{lv:lv, ld:ld, zr:zr, rq:rq, use_exp:0, e_kv:0, e_grant:0,
          e_data:0, e_count:0, e_lr:0};
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    load_valid = 0; zeroize = 0; req = 0;
    #2;
    chk("rst_load_ready", int'(load_ready), 0);
    chk("rst_key_valid", int'(key_valid), 0);
    chk("rst_grant", int'(grant), 0);
    chk("rst_key_data", int'(key_data), 0);
    chk("rst_pad_empty", int'(pad_empty), 1);
    chk("rst_pad_full", int'(pad_full), 0);
    chk("rst_pad_count", int'(pad_count), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    #1;
    chk("post_rst_load_ready", int'(load_ready), 1);
  endtask

  vec_t tab[8];
  int   lr_low, budget;

  initial begin
    model_reset();
    do_reset();

    // Three bytes, encryptor requesting: keys on alternate cycles, in order.
    tab[0] = '{1, 8'hA5, 0, 2'b01, 1, 0, 2'b00, 8'h00, 0, 1};
    tab[1] = '{1, 8'h3C, 0, 2'b01, 1, 0, 2'b00, 8'h00, 1, 1};
    tab[2] = '{1, 8'h7E, 0, 2'b01, 1, 1, 2'b01, 8'hA5, 2, 1};
    tab[3] = '{0, 8'h00, 0, 2'b01, 1, 0, 2'b00, 8'h00, 2, 1};
    tab[4] = '{0, 8'h00, 0, 2'b01, 1, 1, 2'b01, 8'h3C, 2, 1};
    tab[5] = '{0, 8'h00, 0, 2'b01, 1, 0, 2'b00, 8'h00, 1, 1};
    tab[6] = '{0, 8'h00, 0, 2'b00, 1, 1, 2'b01, 8'h7E, 1, 1};
    tab[7] = '{0, 8'h00, 0, 2'b00, 1, 0, 2'b00, 8'h00, 0, 1};
    foreach (tab[i]) step(tab[i]);
    chk("seq1_empty", int'(pad_empty), 1);

    // Both requesting: grants alternate (requester 1 first, 0 took the last one).
    for (int i = 0; i < 4; i++) step(mk(1, 8'(8'h10 + i), 0, 2'b00));
    chk("rr_count4", int'(pad_count), 4);
    for (int i = 0; i < 8; i++) step(mk(0, 0, 0, 2'b11));
    chk("rr_count0", int'(pad_count), 0);

    // Fill to full, a ninth offer is ignored, one issue reopens the loader.
    for (int i = 0; i < DEPTH; i++) step(mk(1, 8'(8'h40 + i), 0, 2'b00));
    chk("full_flag", int'(pad_full), 1);
    chk("full_ready", int'(load_ready), 0);
    step(mk(1, 8'hEE, 0, 2'b00));
    step(mk(0, 0, 0, 2'b10));
    step(mk(0, 0, 0, 2'b00));
    chk("reopen_ready", int'(load_ready), 1);
    for (int i = 0; i < 20; i++) step(mk(0, 0, 0, 2'b01));

    // Zeroize pulsed during an issue: issue completes, then an 8-cycle wipe.
    for (int i = 0; i < 5; i++) step(mk(1, 8'(8'hC0 + i), 0, 2'b00));
    step(mk(0, 0, 0, 2'b01));
    chk("zr_in_issue", int'(issuing), 1);
    step(mk(0, 0, 1, 2'b00));
    lr_low = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      #1;
      if (!load_ready) lr_low++;
      #1;
      step(mk(0, 0, 0, 2'b00));
    end
    chk("wipe_cycles", lr_low, DEPTH);
    chk("wipe_count", int'(pad_count), 0);
    for (int i = 0; i < DEPTH; i++) chk("wipe_mem", int'(dut.mem[i]), 0);

    // Asynchronous reset in the middle of an issue.
    step(mk(1, 8'h11, 0, 2'b00));
    step(mk(1, 8'h22, 0, 2'b11));
    budget = 0;
    while (!issuing && budget < 10) begin step(mk(0, 0, 0, 2'b11)); budget++; end
    chk("mid_issue_reached", int'(issuing), 1);
    #2;
    chk("mid_issue_kv", int'(key_valid), 1);
    reset = 1'b1;
    #1;
    chk("async_kv", int'(key_valid), 0);
    chk("async_count", int'(pad_count), 0);
    chk("async_empty", int'(pad_empty), 1);
    chk("async_ready", int'(load_ready), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    step(mk(1, 8'h99, 0, 2'b11));
    step(mk(1, 8'h98, 0, 2'b11));
    chk("post_rst_first", int'(grant), 1);
    step(mk(0, 0, 0, 2'b11));

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++)
      step(mk(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 39) == 0),
              2'($urandom)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
